// File: rtl/gate_tester_pkg.sv
`default_nettype none
// ============================================================================
// gate_tester_pkg : FSM states, gate-select codes and the 2-input gate model
// Rev 1.0
// ============================================================================
package gate_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_XOR  = 2'b10;
  localparam logic [1:0] SEL_NAND = 2'b11;

  function automatic logic gate_eval(input logic [1:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      SEL_AND:  y = a & b;
      SEL_OR:   y = a | b;
      SEL_XOR:  y = a ^ b;
      default:  y = ~(a & b);
    endcase
    return y;
  endfunction

  // Index of the lowest mismatching vector; 0 when the mask is clear.
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else if (m[3]) r = 2'd3;
    else           r = 2'd0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : 1-bit two-flop synchroniser, synchronous active-low reset to 0
// Rev 1.0
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/tt_um_gate_tester.sv
`default_nettype none
// ============================================================================
// tt_um_gate_tester : drives a/b to an external 2-input gate tile and checks
// its answer against a truth-table model. Optional: GATE_TESTER_LOOPBACK_EN.
// Rev 1.0
// ============================================================================
module tt_um_gate_tester
  import gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic start_s, resp_s, start_rise;
  logic start_s_d_q;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d, idx_q, idx_d, first_q, first_d;
  logic [3:0]  cnt_q, cnt_d, err_q, err_d;
  logic        a_q, a_d, b_q, b_d, busy_q, busy_d;
  logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic        exp_bit, resp_bit;

  sync_2ff u_sync_start (.clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(start_s));
  sync_2ff u_sync_resp  (.clk(clk), .rst_n(rst_n), .d(ui_in[1]), .q(resp_s));

  assign start_rise = start_s & ~start_s_d_q;
  assign exp_bit    = gate_eval(sel_q, a_q, b_q);

`ifdef GATE_TESTER_LOOPBACK_EN
  assign resp_bit = ui_in[7] ? exp_bit : resp_s;
`else
  assign resp_bit = resp_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_s_d_q <= 1'b0;
      sel_q       <= 2'd0;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      first_q     <= 2'd0;
      err_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      start_s_d_q <= start_s;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      first_q     <= first_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_rise) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == 2'd3) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Results and a/b hold their values outside the states that update them.
  always_comb begin
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    first_d = first_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = 4'd0;
          first_d = 2'd0;
          sel_d   = ui_in[3:2];
          idx_d   = 2'd0;
          busy_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        a_d   = idx_q[1];
        b_d   = idx_q[0];
        cnt_d = CNT_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        if (resp_bit != exp_bit) err_d[idx_q] = 1'b1;
        if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 4'd0);
        fail_d  = |err_q;
        first_d = first_set(err_q);
      end
      default: ;
    endcase
  end

  assign uo_out  = {first_q, fail_q, pass_q, done_q, busy_q, b_q, a_q};
  assign uio_out = {4'd0, err_q};
  assign uio_oe  = 8'h0F;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[7:4], uio_in};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_gate_tester.sv
`default_nettype none
// ============================================================================
// tb_tt_um_gate_tester : table-driven bench with a behavioural external gate
// Rev 1.0
// ============================================================================
module tb_tt_um_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       y = 1'b0;
  logic       l7 = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] y_tab = 4'b0000;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;
  logic [7:0] uio_in = 8'h00;

  int n_pass = 0;
  int n_total = 0;

  assign ui_in = {l7, 3'b000, sel, y, start};

  tt_um_gate_tester #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // External gate tile: answer indexed by vector {a,b}, one cycle late.
  always @(negedge clk) y = y_tab[{uo_out[0], uo_out[1]}];

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [3:0] y_tab;
    logic       l7;
    logic       glitch;
    int         mode;      // 0 pulse, 1 held high, 2 re-trigger while busy
    logic [3:0] exp_mask;
    logic [1:0] exp_first;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic run(input vec_t v, output int t_busy, output int t_done);
    start = 1'b0;
    repeat (5) @(negedge clk);
    sel = v.sel; y_tab = v.y_tab; l7 = v.l7;
    start = 1'b1;
    t_busy = -1; t_done = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (uo_out[2] && t_busy < 0) t_busy = k;
      if (v.mode == 0 && k == 4) start = 1'b0;
      if (t_busy >= 0) begin
        if (v.glitch && k == t_busy + 5) sel = ~v.sel;
        if (v.mode == 2 && k == t_busy + 2) start = 1'b0;
        if (v.mode == 2 && k == t_busy + 7) start = 1'b1;
        if (uo_out[3]) begin t_done = k; break; end
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    int tb, td;
    vec_t v;
    logic pass_e;
    tbl[0] = '{"and_good",     2'b00, 4'b1000, 1'b0, 1'b0, 0, 4'b0000, 2'd0};
    tbl[1] = '{"and_stuck1",   2'b00, 4'b1111, 1'b0, 1'b0, 0, 4'b0111, 2'd0};
    tbl[2] = '{"xor_bad_v3",   2'b10, 4'b1110, 1'b0, 1'b0, 0, 4'b1000, 2'd3};
    tbl[3] = '{"or_good",      2'b01, 4'b1110, 1'b0, 1'b0, 0, 4'b0000, 2'd0};
    tbl[4] = '{"nand_inv",     2'b11, 4'b1000, 1'b0, 1'b0, 0, 4'b1111, 2'd0};
    tbl[5] = '{"or_bad_v12",   2'b01, 4'b1000, 1'b0, 1'b0, 1, 4'b0110, 2'd1};
    tbl[6] = '{"and_selglit",  2'b00, 4'b1000, 1'b0, 1'b1, 2, 4'b0000, 2'd0};
`ifdef GATE_TESTER_LOOPBACK_EN
    tbl[7] = '{"loopback_on",  2'b11, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 2'd0};
`else
    tbl[7] = '{"loopback_ign", 2'b11, 4'b0000, 1'b1, 1'b0, 0, 4'b0111, 2'd0};
`endif

    repeat (3) @(negedge clk);
    chk("rst_uo_out", int'(uo_out), 0);
    chk("rst_uio_out", int'(uio_out), 0);
    chk("uio_oe", int'(uio_oe), 8'h0F);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      run(v, tb, td);
      pass_e = (v.exp_mask == 4'b0000);
      chk({v.name, "_busy_lat"}, tb, 3);
      chk({v.name, "_done_lat"}, td - tb, 25);
      chk({v.name, "_uo_out"}, int'(uo_out),
          int'({v.exp_first, ~pass_e, pass_e, 1'b1, 1'b0, 1'b1, 1'b1}));
      chk({v.name, "_err_mask"}, int'(uio_out), int'({4'b0000, v.exp_mask}));
      if (v.mode != 0) begin
        td = 0;
        repeat (40) begin @(posedge clk); #1; if (uo_out[2]) td++; end
        chk({v.name, "_no_rerun"}, td, 0);
        chk({v.name, "_hold"}, int'(uio_out), int'({4'b0000, v.exp_mask}));
      end
    end

`ifdef GATE_TESTER_LOOPBACK_EN
    v = '{"loopback_off", 2'b11, 4'b0000, 1'b0, 1'b0, 0, 4'b0111, 2'd0};
    run(v, tb, td);
    chk("loopback_off_err_mask", int'(uio_out), 8'h07);
`endif

    // Abort during vector 2 settling, then prove a fresh run still works.
    start = 1'b0; l7 = 1'b0; sel = 2'b00; y_tab = 4'b1111;
    repeat (5) @(negedge clk);
    start = 1'b1;
    tb = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 4) start = 1'b0;
      if (uo_out[2] && tb < 0) tb = k;
      if (tb >= 0 && k == tb + 14) break;
    end
    chk("abort_busy_seen", int'(tb >= 0), 1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_uo_out", int'(uo_out), 0);
    chk("abort_uio_out", int'(uio_out), 0);
    @(negedge clk); rst_n = 1'b1;
    td = 0;
    repeat (40) begin @(posedge clk); #1; if (uo_out[3] || uo_out[2]) td++; end
    chk("abort_no_done", td, 0);
    run(tbl[2], tb, td);
    chk("after_abort_done_lat", td - tb, 25);
    chk("after_abort_uo_out", int'(uo_out), 8'hEB);
    chk("after_abort_err_mask", int'(uio_out), 8'h08);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
